mem_bus_arbiter: RTL and testbench

- Shares the single 32-bit peripheral/data-memory bus between two requesters: instruction fetch (IF) and the load/store memory stage (MEM).
- Sequences each access as a valid/ready transaction with a bounded wait.
- Default priority goes to MEM; an anti-starvation counter lets IF win periodically.
- Sits between the pipeline and the peripheral bus and drives the address, store data and read/write select. Read data returns to the winning requester.

---
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter that shares one 32-bit peripheral bus between instruction fetch and the MEM stage.
// MEM has default priority; a starve counter forces an IF grant, and a watchdog aborts stalled accesses.
module mem_bus_arbiter #(
  parameter int TIMEOUT      = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_l_or_s,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER} state_t;

  state_t      state_reg, state_next;
  logic        valid_reg, valid_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        we_reg, we_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic        if_done_reg, if_done_next;
  logic        mem_done_reg, mem_done_next;
  logic        err_reg, err_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic [31:0] mem_rdata_reg, mem_rdata_next;
  logic        if_wins;

  // IF wins when it is alone, or when MEM has starved it for STARVE_LIMIT grants.
  assign if_wins = if_req && (!mem_req || (starve_reg == SW'(STARVE_LIMIT)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      valid_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      we_reg        <= 1'b0;
      tcnt_reg      <= '0;
      starve_reg    <= '0;
      if_done_reg   <= 1'b0;
      mem_done_reg  <= 1'b0;
      err_reg       <= 1'b0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      valid_reg     <= valid_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      we_reg        <= we_next;
      tcnt_reg      <= tcnt_next;
      starve_reg    <= starve_next;
      if_done_reg   <= if_done_next;
      mem_done_reg  <= mem_done_next;
      err_reg       <= err_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    valid_next     = valid_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    we_next        = we_reg;
    tcnt_next      = tcnt_reg;
    starve_next    = starve_reg;
    if_done_next   = 1'b0;
    mem_done_next  = 1'b0;
    err_next       = 1'b0;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (if_wins) begin
          state_next  = IF_XFER;
          valid_next  = 1'b1;
          addr_next   = if_addr;
          wdata_next  = '0;
          we_next     = 1'b0;
          tcnt_next   = '0;
          starve_next = '0;
        end else if (mem_req) begin
          state_next = MEM_XFER;
          valid_next = 1'b1;
          addr_next  = mem_addr;
          wdata_next = mem_wdata;
          we_next    = ~mem_l_or_s;
          tcnt_next  = '0;
          if (if_req && (starve_reg < SW'(STARVE_LIMIT)))
            starve_next = starve_reg + 1'b1;
        end
      end
      IF_XFER, MEM_XFER: begin
        if (bus_ready || (tcnt_reg == TW'(TIMEOUT - 1))) begin
          state_next = IDLE;
          valid_next = 1'b0;
          err_next   = ~bus_ready;
          if (state_reg == IF_XFER) begin
            if_done_next  = 1'b1;
            if_rdata_next = bus_ready ? bus_rdata : '0;
          end else begin
            mem_done_next = 1'b1;
            // A completed store leaves the load data untouched; an aborted access clears it.
            if (!bus_ready)
              mem_rdata_next = '0;
            else if (!we_reg)
              mem_rdata_next = bus_rdata;
          end
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign if_done   = if_done_reg;
  assign if_rdata  = if_rdata_reg;
  assign mem_done  = mem_done_reg;
  assign mem_rdata = mem_rdata_reg;
  assign bus_valid = valid_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign bus_we    = we_reg;
  assign bus_err   = err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, load/store, contention, timeout and dropped-request cases.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_l_or_s = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_l_or_s(mem_l_or_s), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus_valid), 32'h0);
    chk({tag, ".addr"}, bus_addr, 32'h0);
    chk({tag, ".wdata"}, bus_wdata, 32'h0);
    chk({tag, ".we"}, 32'(bus_we), 32'h0);
    chk({tag, ".err"}, 32'(bus_err), 32'h0);
    chk({tag, ".if_done"}, 32'(if_done), 32'h0);
    chk({tag, ".mem_done"}, 32'(mem_done), 32'h0);
    chk({tag, ".if_rdata"}, if_rdata, 32'h0);
    chk({tag, ".mem_rdata"}, mem_rdata, 32'h0);
  endtask

  logic [9:0] exp_if_seq;

  initial begin
    // Reset state
    tick();
    chk_all_zero("rst_init");
    rst = 1'b1;
    tick(); tick();
    chk("idle_valid", 32'(bus_valid), 32'h0);
    $display("txn reset/idle done");

    // Single zero-wait load
    mem_req = 1'b1; mem_l_or_s = 1'b1; mem_addr = 32'h1000_0004;
    tick();
    chk("ld_valid", 32'(bus_valid), 32'h1);
    chk("ld_addr", bus_addr, 32'h1000_0004);
    chk("ld_we", 32'(bus_we), 32'h0);
    chk("ld_done_early", 32'(mem_done), 32'h0);
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF; mem_req = 1'b0;
    tick();
    chk("ld_done", 32'(mem_done), 32'h1);
    chk("ld_valid_drop", 32'(bus_valid), 32'h0);
    chk("ld_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("ld_err", 32'(bus_err), 32'h0);
    bus_ready = 1'b0;
    tick();
    chk("ld_done_pulse", 32'(mem_done), 32'h0);
    $display("txn load addr=%h rdata=%h", 32'h1000_0004, mem_rdata);

    // Store with three wait cycles
    mem_req = 1'b1; mem_l_or_s = 1'b0; mem_addr = 32'h20; mem_wdata = 32'h55AA_55AA;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_valid", 32'(bus_valid), 32'h1);
      chk("st_we", 32'(bus_we), 32'h1);
      chk("st_wdata", bus_wdata, 32'h55AA_55AA);
      chk("st_addr", bus_addr, 32'h20);
      chk("st_done_early", 32'(mem_done), 32'h0);
      mem_addr = 32'hFFFF_0000; mem_wdata = 32'h0;
      if (i == 3) begin
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678; mem_req = 1'b0;
      end
      tick();
    end
    chk("st_done", 32'(mem_done), 32'h1);
    chk("st_rdata_keep", mem_rdata, 32'hDEAD_BEEF);
    chk("st_valid_drop", 32'(bus_valid), 32'h0);
    bus_ready = 1'b0;
    tick();
    $display("txn store addr=%h wdata=%h", 32'h20, 32'h55AA_55AA);

    // Contention: MEM x4, then IF, repeated
    exp_if_seq = 10'b10000_10000;
    if_req = 1'b1; if_addr = 32'h400;
    mem_req = 1'b1; mem_l_or_s = 1'b1; mem_addr = 32'h800;
    bus_ready = 1'b1; bus_rdata = 32'hA5A5_0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("arb_valid", 32'(bus_valid), 32'h1);
      chk("arb_addr", bus_addr, exp_if_seq[k] ? 32'h400 : 32'h800);
      if (k == 9) begin
        if_req = 1'b0; mem_req = 1'b0;
      end
      tick();
      chk("arb_if_done", 32'(if_done), 32'(exp_if_seq[k]));
      chk("arb_mem_done", 32'(mem_done), 32'(!exp_if_seq[k]));
      chk("arb_overlap", 32'(if_done & mem_done), 32'h0);
      $display("txn grant %0d winner=%s", k, exp_if_seq[k] ? "IF" : "MEM");
      bus_rdata = bus_rdata + 1;
    end
    chk("arb_if_rdata", if_rdata, 32'hA5A5_000A);
    chk("arb_mem_rdata", mem_rdata, 32'hA5A5_0009);
    bus_ready = 1'b0;
    tick();
    chk("arb_idle", 32'(bus_valid), 32'h0);

    // IF timeout
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_valid", 32'(bus_valid), 32'h1);
      chk("to_done_early", 32'(if_done), 32'h0);
      if (i == 15) if_req = 1'b0;
      if (i < 15) tick();
    end
    tick();
    chk("to_done", 32'(if_done), 32'h1);
    chk("to_err", 32'(bus_err), 32'h1);
    chk("to_rdata", if_rdata, 32'h0);
    chk("to_valid_drop", 32'(bus_valid), 32'h0);
    tick();
    chk("to_err_pulse", 32'(bus_err), 32'h0);
    chk("to_idle", 32'(bus_valid), 32'h0);
    $display("txn timeout addr=%h err observed", 32'h44);

    // Request dropped mid-transfer
    mem_req = 1'b1; mem_l_or_s = 1'b1; mem_addr = 32'h30;
    tick();
    mem_req = 1'b0;
    tick();
    chk("drop_valid", 32'(bus_valid), 32'h1);
    chk("drop_addr", bus_addr, 32'h30);
    bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    chk("drop_done", 32'(mem_done), 32'h1);
    chk("drop_rdata", mem_rdata, 32'hCAFE_F00D);
    bus_ready = 1'b0;
    tick();
    $display("txn dropped-req load rdata=%h", mem_rdata);

    // Asynchronous reset in the middle of a MEM transfer
    mem_req = 1'b1; mem_l_or_s = 1'b1; mem_addr = 32'h1000_0008;
    tick();
    chk("mr_valid", 32'(bus_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("mr_async");
    mem_req = 1'b0;
    tick();
    chk("mr_no_done", 32'(mem_done), 32'h0);
    rst = 1'b1;
    tick(); tick();
    chk("mr_idle", 32'(bus_valid), 32'h0);
    chk("mr_no_done2", 32'(mem_done), 32'h0);
    $display("txn mid-transfer reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
